// File: rtl/alu_r32i.sv
// RV32I execute-stage integer ALU: combinational operation select feeding a
// single output pipeline register with valid tracking and a zero flag.
module alu_r32i #(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] A,
  input  logic [dataW-1:0] B,
  input  logic [3:0]       alucode,
  input  logic             in_valid,
  output logic [dataW-1:0] result,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SSL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SSR  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_CPY  = 4'b1111;

  logic [dataW-1:0] next_result;
  logic [4:0]       shamt;
  logic             lt_signed;
  logic             lt_unsigned;

  logic [dataW-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             out_valid_d, out_valid_q;

  assign shamt       = B[4:0];
  assign lt_signed   = ($signed(A) < $signed(B));
  assign lt_unsigned = (A < B);

  // Operation select; unassigned codes deliberately yield zero.
  always_comb begin
    next_result = {dataW{1'b0}};
    case (alucode)
      OP_ADD:  next_result = A + B;
      OP_SUB:  next_result = A - B;
      OP_SSL:  next_result = A << shamt;
      OP_SLT:  next_result = {{(dataW-1){1'b0}}, lt_signed};
      OP_SLTU: next_result = {{(dataW-1){1'b0}}, lt_unsigned};
      OP_XOR:  next_result = A ^ B;
      OP_SSR:  next_result = A >> shamt;
      OP_OR:   next_result = A | B;
      OP_AND:  next_result = A & B;
      OP_SRA:  next_result = $unsigned($signed(A) >>> shamt);
      OP_CPY:  next_result = B;
      default: next_result = {dataW{1'b0}};
    endcase
  end

  // Result and flag only update on accepted transactions; valid is a pulse.
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      result_d    = next_result;
      zero_d      = (next_result == {dataW{1'b0}});
      out_valid_d = 1'b1;
    end else begin
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
    end
  end

  // Output pipeline register; reset wins over a transaction on the same edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      result_q    <= {dataW{1'b0}};
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_r32i.sv
// Self-checking bench for alu_r32i: directed plan vectors plus randomized
// traffic compared against an arithmetic reference model.
module tb_alu_r32i;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  alucode;
  logic        in_valid;
  logic [31:0] result;
  logic        zero;
  logic        out_valid;

  int n_checks;
  int n_errors;

  logic [31:0] exp_result;
  logic        exp_zero;
  logic        exp_valid;

  alu_r32i #(.dataW(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .alucode   (alucode),
    .in_valid  (in_valid),
    .result    (result),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] code);
    longint ua, ub, sa, sb, p, r;
    int sh;
    logic [63:0] rv;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32'd32);
    p = 64'sd1;
    for (int i = 0; i < sh; i++) p = p * 64'sd2;
    case (code)
      4'd0:    r = ua + ub;
      4'd8:    r = ua - ub;
      4'd1:    r = ua * p;
      4'd5:    r = ua / p;
      4'd13:   r = (sa >= 64'sd0) ? sa / p : -((-sa - 64'sd1) / p) - 64'sd1;
      4'd2:    r = (sa < sb) ? 64'sd1 : 64'sd0;
      4'd3:    r = (ua < ub) ? 64'sd1 : 64'sd0;
      4'd4:    r = ua ^ ub;
      4'd6:    r = ua | ub;
      4'd7:    r = ua & ub;
      4'd15:   r = ub;
      default: r = 64'sd0;
    endcase
    rv = r;
    return rv[31:0];
  endfunction

  // One clock edge with the given inputs; update the model and check outputs.
  task automatic step(input logic rst, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] code);
    reset    = rst;
    in_valid = v;
    A        = a;
    B        = b;
    alucode  = code;
    @(posedge clock);
    if (!rst) begin
      exp_result = 32'd0;
      exp_zero   = 1'b0;
      exp_valid  = 1'b0;
    end else if (v) begin
      exp_result = ref_alu(a, b, code);
      exp_zero   = (exp_result == 32'd0);
      exp_valid  = 1'b1;
    end else begin
      exp_valid  = 1'b0;
    end
    #1;
    chk("result", result, exp_result);
    chk("zero", {31'd0, zero}, {31'd0, exp_zero});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
  endtask

  // Directed operation with a hand-computed expected result.
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] code, input logic [31:0] want);
    step(1'b1, 1'b1, a, b, code);
    chk(tag, result, want);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_result = 32'd0;
    exp_zero   = 1'b0;
    exp_valid  = 1'b0;
    reset = 1'b0; in_valid = 1'b0; A = 32'd0; B = 32'd0; alucode = 4'd0;

    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'd9, 32'd4, 4'b0000);
      chk("rst_result", result, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'd9, 32'd4, 4'b0000);
      chk("hold_result", result, 32'd0);
      chk("hold_zero", {31'd0, zero}, 32'd0);
    end

    op("add",       32'd9, 32'd4, 4'b0000, 32'd13);
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    op("slt_9_4",   32'd9, 32'd4, 4'b0010, 32'd0);
    op("slt_2_4",   32'd2, 32'd4, 4'b0010, 32'd1);
    op("sltu_2_4",  32'd2, 32'd4, 4'b0011, 32'd1);
    op("sltu_9_4",  32'd9, 32'd4, 4'b0011, 32'd0);
    op("sltu_m2_4", -32'sd2, 32'd4, 4'b0011, 32'd0);
    op("sltu_m2_m1", -32'sd2, -32'sd1, 4'b0011, 32'd1);
    op("slt_m2_4",  -32'sd2, 32'd4, 4'b0010, 32'd1);
    op("and",       32'd9, 32'd5, 4'b0111, 32'd1);
    op("or",        32'd9, 32'd5, 4'b0110, 32'd13);
    op("xor",       32'd9, 32'd5, 4'b0100, 32'd12);
    op("ssl_1",     32'd9, 32'd1, 4'b0001, 32'd18);
    op("ssl_3",     32'd9, 32'd3, 4'b0001, 32'd72);
    op("ssr_3",     32'd9, 32'd3, 4'b0101, 32'd1);
    op("sra_3",     32'd9, 32'd3, 4'b1101, 32'd1);
    op("sra_neg",   -32'sd9, 32'd3, 4'b1101, 32'hFFFF_FFFE);
    op("ssr_neg",   -32'sd9, 32'd3, 4'b0101, 32'h1FFF_FFFE);
    op("ssl_b21",   32'd9, 32'h0000_0021, 4'b0001, 32'd18);
    op("sra_sh0",   -32'sd9, 32'd0, 4'b1101, 32'hFFFF_FFF7);
    op("cpy",       -32'sd9, 32'd3, 4'b1111, 32'd3);
    op("sub",       32'd9, 32'd3, 4'b1000, 32'd6);
    op("sub_wrap",  32'd9, 32'd10, 4'b1000, 32'hFFFF_FFFF);
    op("sub_neg",   -32'sd78, -32'sd901, 4'b1000, 32'd823);
    op("sub_zero",  32'd5, 32'd5, 4'b1000, 32'd0);
    chk("sub_zero_flag", {31'd0, zero}, 32'd1);
    op("add_ovf",   32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000);
    op("undef",     32'd9, 32'd5, 4'b1010, 32'd0);
    chk("undef_zero_flag", {31'd0, zero}, 32'd1);

    op("gap_add1", 32'd1, 32'd2, 4'b0000, 32'd3);
    step(1'b1, 1'b0, 32'd100, 32'd200, 4'b0000);
    chk("gap_valid", {31'd0, out_valid}, 32'd0);
    chk("gap_hold", result, 32'd3);
    op("gap_add2", 32'd4, 32'd5, 4'b0000, 32'd9);

    op("pre_rst", 32'd20, 32'd22, 4'b0000, 32'd42);
    step(1'b0, 1'b1, 32'd7, 32'd7, 4'b0000);
    chk("midrst_result", result, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    op("post_rst", 32'd7, 32'd7, 4'b0000, 32'd14);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      logic [3:0]  rc;
      logic        rv, rr;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      rc = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 9) < 8);
      rr = ($urandom_range(0, 49) != 0);
      step(rr, rv, ra, rb, rc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_r32i.md
# alu_r32i

Integer ALU for the RV32I execute stage: combines two 32-bit operands under a 4-bit operation code and produces a registered 32-bit result plus a zero flag. Sits between the register-file/immediate operand mux and the writeback/branch-compare logic. Single clock domain with a one-cycle pipeline register on the output.

## Interface
- `dataW`, default 32: operand and result width. Only 32 is supported; shift amounts use B[4:0].
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low reset. The block resets on a rising `clock` edge when `reset`=0.
- `A`  in  dataW: operand A, two's complement.
- `B`  in  dataW: operand B, two's complement. Also carries the shift amount and the copy source.
- `alucode`  in  4: operation select.
- `in_valid`  in  1: operands and `alucode` are valid this cycle.
- `result`  out  dataW: registered operation result.
- `zero`  out  1: registered flag, 1 when `result`==0.
- `out_valid`  out  1: `result` and `zero` correspond to a transaction accepted on the previous edge.

## Operation
- Encoding is {funct7[5], funct3}:
  - ADD=4'b0000: A+B, mod 2^32, carry discarded.
  - SUB=4'b1000: A−B, mod 2^32.
  - SSL=4'b0001: A << B[4:0], logical.
  - SLT=4'b0010: 1 if $signed(A) < $signed(B), else 0. Zero-extended to 32 bits.
  - SLTU=4'b0011: 1 if $unsigned(A) < $unsigned(B), else 0.
  - XOR=4'b0100: A^B.
  - SSR=4'b0101: A >> B[4:0], logical, zero fill.
  - OR=4'b0110: A|B.
  - AND=4'b0111: A&B.
  - SRA=4'b1101: A >>> B[4:0], arithmetic, sign fill.
  - CPY=4'b1111: B passed through unchanged, used for LUI.
- Any other code produces result 0. This is not an error.
- B[31:5] is ignored for all shifts. A shift amount of 0 returns A.
- No overflow or carry flags. Signed overflow wraps silently.
- The next result is computed combinationally from A, B and `alucode`, then registered.

## Timing
- On each rising `clock` edge with `reset`=1:
  - If `in_valid`=1: `result` ← next result; `zero` ← (next result==0); `out_valid` ← 1.
  - If `in_valid`=0: `result` and `zero` hold their values; `out_valid` ← 0.
- Latency is 1 cycle, with a throughput of one operation per cycle. There is no backpressure and no stall input.
- Reset, on an edge with `reset`=0: `result`=0, `zero`=0, `out_valid`=0. Reset takes priority over `in_valid`. A transaction presented on the reset edge is discarded.
- After `reset` deasserts, the first `in_valid` edge produces `out_valid`=1 on the following cycle.
- Back-to-back transactions: each output reflects exactly the inputs from the preceding edge, with no mixing.
- Inputs may change freely between edges. Only values at the rising edge matter.

## Test plan
- Reset and hold:
  - Assert `reset`=0 for 2 edges with `in_valid`=1 and A=9, B=4, ADD -> `result`=0, `zero`=0, `out_valid`=0 throughout.
  - Release reset, then hold `in_valid`=0 -> outputs stay at their reset values.
- Arithmetic and compares, one operation per cycle with `in_valid`=1. Each result appears one cycle later.
  - ADD 9,4 -> 13.
  - SLT 9,4 -> 0.
  - SLT 2,4 -> 1.
  - SLTU 2,4 -> 1.
  - SLTU 9,4 -> 0.
  - SLTU −2,4 -> 0.
  - SLTU −2,−1 -> 1.
- Logic and shifts:
  - AND 9,5 -> 1.
  - OR 9,5 -> 13.
  - XOR 9,5 -> 12.
  - SSL 9,1 -> 18.
  - SSL 9,3 -> 72.
  - SSR 9,3 -> 1.
  - SRA 9,3 -> 1.
  - SRA −9,3 -> 0xFFFFFFFE.
  - SSR −9,3 -> 0x1FFFFFFE.
  - SSL with B=0x00000021 -> same as shift 1.
- Copy, subtract and zero flag:
  - CPY A=−9,B=3 -> 3.
  - SUB 9,3 -> 6.
  - SUB 9,10 -> 0xFFFFFFFF.
  - SUB −78,−901 -> 823.
  - SUB 5,5 -> 0 with `zero`=1.
  - Undefined code 4'b1010 -> 0 with `zero`=1.
- Valid gating and mid-stream reset:
  - Drop `in_valid` for one cycle between two ADDs -> `out_valid` drops to 0 for that cycle and `result` holds the prior value.
  - Assert `reset`=0 on the edge after a transaction is accepted -> the following cycle shows the reset values, not that transaction's result.
